// File: rtl/branch_history_queue.sv
// rtl/branch_history_queue.sv - GHR-hashed lookup front end with pending-branch queue for a two-bit-counter table
module branch_history_queue #(
    parameter int IDX_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   br_valid,
    input  logic [IDX_W-1:0]       br_pc,
    output logic                   br_ready,
    output logic                   pred_valid,
    output logic                   pred_taken,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic                   flush,
    output logic                   tbl_get,
    output logic [IDX_W-1:0]       tbl_get_index,
    input  logic                   tbl_prediction,
    output logic                   tbl_set,
    output logic [IDX_W-1:0]       tbl_set_index,
    output logic                   tbl_feedback,
    output logic                   tbl_reset,
    output logic [IDX_W-1:0]       tbl_reset_index,
    output logic                   mispredict,
    output logic [15:0]            mispredict_count,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ghr;
    logic [IDX_W-1:0]  q_idx [DEPTH];
    logic [DEPTH-1:0]  q_pred;
    logic [DEPTH-1:0]  q_filled;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  s1_tag;
    logic [PTR_W-1:0]  s2_tag;
    logic              s2_live;

    logic              in_run;
    logic              do_clear;
    logic              do_flush;
    logic              do_accept;
    logic              do_resolve;
    logic              do_fill;
    logic [IDX_W-1:0]  hash;

    always_comb begin
        in_run     = (state == S_RUN);
        br_ready   = in_run && (occupancy < OCC_FULL);
        do_clear   = in_run && clear;
        do_flush   = in_run && (flush || clear);
        do_accept  = br_valid && br_ready && !do_flush;
        do_resolve = in_run && res_valid && !do_flush &&
                     (occupancy != '0) && q_filled[head];
        // A lookup whose entry was flushed while in flight must not fill anything.
        do_fill    = s2_live && !do_flush;
        hash       = br_pc ^ ghr;
    end

    // Entry payload needs no reset: occupancy and s2_live gate every read.
    always_ff @(posedge clk) begin
        if (do_accept) begin
            q_idx[tail]    <= hash;
            q_filled[tail] <= 1'b0;
        end
        if (do_fill) begin
            q_pred[s2_tag]   <= tbl_prediction;
            q_filled[s2_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_INIT;
            ghr              <= '0;
            head             <= '0;
            tail             <= '0;
            occupancy        <= '0;
            s1_tag           <= '0;
            s2_tag           <= '0;
            s2_live          <= 1'b0;
            pred_valid       <= 1'b0;
            pred_taken       <= 1'b0;
            tbl_get          <= 1'b0;
            tbl_get_index    <= '0;
            tbl_set          <= 1'b0;
            tbl_set_index    <= '0;
            tbl_feedback     <= 1'b0;
            tbl_reset        <= 1'b0;
            tbl_reset_index  <= '0;
            mispredict       <= 1'b0;
            mispredict_count <= '0;
        end else begin
            tbl_get    <= 1'b0;
            tbl_set    <= 1'b0;
            pred_valid <= 1'b0;
            mispredict <= 1'b0;

            case (state)
                S_INIT: begin
                    if (!tbl_reset) begin
                        tbl_reset       <= 1'b1;
                        tbl_reset_index <= '0;
                    end else if (tbl_reset_index == '1) begin
                        tbl_reset       <= 1'b0;
                        tbl_reset_index <= '0;
                        state           <= S_RUN;
                    end else begin
                        tbl_reset_index <= tbl_reset_index + IDX_W'(1);
                    end
                end
                S_RUN: begin
                    // Clear starts the sweep on the very next cycle, no idle gap.
                    if (do_clear) begin
                        state           <= S_INIT;
                        tbl_reset       <= 1'b1;
                        tbl_reset_index <= '0;
                    end
                end
                default: state <= S_INIT;
            endcase

            if (do_clear) begin
                ghr <= '0;
            end else if (do_resolve) begin
                ghr <= {ghr[IDX_W-2:0], res_taken};
            end

            if (do_accept) begin
                tbl_get       <= 1'b1;
                tbl_get_index <= hash;
                s1_tag        <= tail;
            end
            s2_live <= tbl_get && !do_flush;
            s2_tag  <= s1_tag;

            if (do_fill) begin
                pred_valid <= 1'b1;
                pred_taken <= tbl_prediction;
            end

            if (do_resolve) begin
                tbl_set       <= 1'b1;
                tbl_set_index <= q_idx[head];
                tbl_feedback  <= res_taken;
                if (res_taken != q_pred[head]) begin
                    mispredict <= 1'b1;
                    if (mispredict_count != 16'hFFFF) begin
                        mispredict_count <= mispredict_count + 16'd1;
                    end
                end
            end

            if (do_flush) begin
                head      <= '0;
                tail      <= '0;
                occupancy <= '0;
            end else begin
                if (do_accept) begin
                    tail <= tail + PTR_ONE;
                end
                if (do_resolve) begin
                    head <= head + PTR_ONE;
                end
                if (do_accept && !do_resolve) begin
                    occupancy <= occupancy + OCC_ONE;
                end else if (!do_accept && do_resolve) begin
                    occupancy <= occupancy - OCC_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_history_queue.sv
// tb/tb_branch_history_queue.sv - randomized and directed bench for branch_history_queue with transaction-level model
`timescale 1ns/1ps
module tb_branch_history_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        br_valid = 1'b0;
    logic [7:0]  br_pc = 8'h00;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        flush = 1'b0;
    logic        tbl_prediction = 1'b0;
    logic        br_ready, pred_valid, pred_taken, tbl_get, tbl_set, tbl_feedback;
    logic        tbl_reset, mispredict;
    logic [7:0]  tbl_get_index, tbl_set_index, tbl_reset_index;
    logic [15:0] mispredict_count;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;

    branch_history_queue #(.IDX_W(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .br_valid(br_valid), .br_pc(br_pc), .br_ready(br_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .tbl_get(tbl_get), .tbl_get_index(tbl_get_index), .tbl_prediction(tbl_prediction),
        .tbl_set(tbl_set), .tbl_set_index(tbl_set_index), .tbl_feedback(tbl_feedback),
        .tbl_reset(tbl_reset), .tbl_reset_index(tbl_reset_index),
        .mispredict(mispredict), .mispredict_count(mispredict_count), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Table with one cycle of read latency; returns noise when no lookup is due.
    bit tbl_bits [256];
    bit nxt_valid = 1'b0;
    bit nxt_val = 1'b0;
    always @(negedge clk) begin
        tbl_prediction = nxt_valid ? nxt_val : 1'($urandom_range(0, 1));
        nxt_valid = tbl_get;
        nxt_val = tbl_bits[tbl_get_index];
    end

    typedef struct { logic [7:0] idx; bit pred; bit filled; int tk; } ent_t;
    typedef struct { int tk; int age; logic [7:0] idx; } lk_t;

    ent_t       q[$];
    lk_t        infl[$];
    logic [7:0] m_ghr;
    int         m_cnt, m_pos, m_tk;
    bit         m_run;
    bit         e_get, e_set, e_fb, e_misp, e_pv, e_pt;
    logic [7:0] e_get_idx, e_set_idx;

    task automatic model_reset();
        q.delete();
        infl.delete();
        m_ghr = 8'h00; m_cnt = 0; m_pos = -2; m_run = 1'b0; m_tk = 0;
        e_get = 0; e_set = 0; e_fb = 0; e_misp = 0; e_pv = 0; e_pt = 0;
    endtask

    // Apply the current inputs to the model for one edge, then advance the DUT.
    task automatic tick();
        bit acc, res, fl, cl;
        ent_t ne;
        lk_t nl;
        e_get = 0; e_set = 0; e_misp = 0; e_pv = 0;
        fl  = m_run && flush;
        cl  = m_run && clear;
        acc = m_run && br_valid && !fl && !cl && (q.size() < 4);
        res = m_run && res_valid && !fl && !cl && (q.size() > 0) && q[0].filled;
        if (acc) begin
            e_get = 1;
            e_get_idx = br_pc ^ m_ghr;
        end
        if (res) begin
            e_set = 1;
            e_set_idx = q[0].idx;
            e_fb = res_taken;
            e_misp = (res_taken != q[0].pred);
            if (e_misp && m_cnt < 65535) m_cnt++;
            m_ghr = {m_ghr[6:0], res_taken};
            q.delete(0);
        end
        if (fl || cl) q.delete();
        if (cl) begin
            m_ghr = 8'h00; m_run = 1'b0; m_pos = 0;
        end else if (m_pos == -2) begin
            m_pos = 0;
        end else if (m_pos == 255) begin
            m_pos = -1; m_run = 1'b1;
        end else if (m_pos >= 0) begin
            m_pos++;
        end
        foreach (infl[i]) begin
            infl[i].age--;
            if (infl[i].age == 0) begin
                foreach (q[j]) begin
                    if (q[j].tk == infl[i].tk) begin
                        q[j].filled = 1;
                        q[j].pred = tbl_bits[infl[i].idx];
                        e_pv = 1;
                        e_pt = q[j].pred;
                    end
                end
            end
        end
        while (infl.size() > 0 && infl[0].age <= 0) infl.delete(0);
        if (acc) begin
            ne.idx = e_get_idx; ne.pred = 0; ne.filled = 0; ne.tk = m_tk;
            q.push_back(ne);
            nl.tk = m_tk; nl.age = 2; nl.idx = e_get_idx;
            infl.push_back(nl);
            m_tk++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        br_valid = 0; res_valid = 0; res_taken = 0; flush = 0; clear = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({br_ready, pred_valid, tbl_get, tbl_set, tbl_reset, mispredict} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags got %b want 000000", {br_ready, pred_valid, tbl_get, tbl_set, tbl_reset, mispredict});
        end
        n_checks++;
        if ({mispredict_count, occupancy, tbl_reset_index, tbl_get_index, tbl_set_index} !== 43'b0) begin
            n_errors++;
            $display("FAIL reset_values cnt=%h occ=%0d rix=%h gix=%h six=%h want all 0",
                     mispredict_count, occupancy, tbl_reset_index, tbl_get_index, tbl_set_index);
        end
        model_reset();
        reset = 0;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 256; i++) begin
            tick();
            n_checks++;
            if (tbl_reset !== 1'b1 || tbl_reset_index !== 8'(i) || br_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL sweep step %0d got rst=%b idx=%h rdy=%b want 1 %h 0", i, tbl_reset, tbl_reset_index, br_ready, 8'(i));
            end
        end
        tick();
        n_checks++;
        if (tbl_reset !== 1'b0 || br_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL sweep_end got rst=%b rdy=%b want 0 1", tbl_reset, br_ready);
        end
    endtask

    task automatic test_hash();
        for (int i = 0; i < 256; i++) tbl_bits[i] = 1'b1;
        br_pc = 8'h05; br_valid = 1; tick(); br_valid = 0;
        n_checks++;
        if (tbl_get !== 1'b1 || tbl_get_index !== 8'h05) begin
            n_errors++;
            $display("FAIL hash_ghr0 got get=%b idx=%h want 1 05", tbl_get, tbl_get_index);
        end
        tick();
        n_checks++;
        if (pred_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL pred_early got pred_valid=%b want 0", pred_valid);
        end
        tick();
        n_checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL pred_return got v=%b t=%b want 1 1", pred_valid, pred_taken);
        end
        res_valid = 1; res_taken = 1; tick(); res_valid = 0;
        n_checks++;
        if (tbl_set !== 1'b1 || tbl_set_index !== 8'h05 || tbl_feedback !== 1'b1 || mispredict !== 1'b0) begin
            n_errors++;
            $display("FAIL resolve_ok got set=%b idx=%h fb=%b misp=%b want 1 05 1 0", tbl_set, tbl_set_index, tbl_feedback, mispredict);
        end
        br_pc = 8'h20; br_valid = 1; tick(); br_valid = 0;
        n_checks++;
        if (tbl_get_index !== 8'h21) begin
            n_errors++;
            $display("FAIL hash_ghr1 got idx=%h want 21", tbl_get_index);
        end
        tick(); tick();
        res_valid = 1; res_taken = 1; tick(); res_valid = 0;
        tbl_bits[8'h06] = 1'b0;
        br_pc = 8'h05; br_valid = 1; tick(); br_valid = 0;
        n_checks++;
        if (tbl_get !== 1'b1 || tbl_get_index !== 8'h06) begin
            n_errors++;
            $display("FAIL hash_ghr3 got get=%b idx=%h want 1 06", tbl_get, tbl_get_index);
        end
    endtask

    task automatic test_mispredict();
        tick(); tick();
        n_checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL misp_pred got v=%b t=%b want 1 0", pred_valid, pred_taken);
        end
        res_valid = 1; res_taken = 1; tick(); res_valid = 0;
        n_checks++;
        if (tbl_set !== 1'b1 || tbl_feedback !== 1'b1 || tbl_set_index !== 8'h06 ||
            mispredict !== 1'b1 || mispredict_count !== 16'd1) begin
            n_errors++;
            $display("FAIL misp_update got set=%b fb=%b idx=%h misp=%b cnt=%0d want 1 1 06 1 1",
                     tbl_set, tbl_feedback, tbl_set_index, mispredict, mispredict_count);
        end
        br_pc = 8'h10; br_valid = 1; tick(); br_valid = 0;
        n_checks++;
        if (mispredict !== 1'b0 || tbl_get_index !== 8'h17) begin
            n_errors++;
            $display("FAIL misp_pulse got misp=%b idx=%h want 0 17", mispredict, tbl_get_index);
        end
        tick(); tick();
        res_valid = 1; res_taken = 1; tick(); res_valid = 0;
        n_checks++;
        if (tbl_set !== 1'b1 || mispredict !== 1'b0 || mispredict_count !== 16'd1) begin
            n_errors++;
            $display("FAIL correct_resolve got set=%b misp=%b cnt=%0d want 1 0 1", tbl_set, mispredict, mispredict_count);
        end
    endtask

    task automatic test_full();
        logic [7:0] pc;
        for (int i = 0; i < 4; i++) begin
            pc = 8'($urandom);
            tbl_bits[pc ^ m_ghr] = 1'($urandom_range(0, 1));
            br_pc = pc; br_valid = 1; tick();
            n_checks++;
            if (tbl_get !== 1'b1 || tbl_get_index !== (pc ^ m_ghr)) begin
                n_errors++;
                $display("FAIL b2b_get %0d got get=%b idx=%h want 1 %h", i, tbl_get, tbl_get_index, pc ^ m_ghr);
            end
            n_checks++;
            if (pred_valid !== e_pv || (e_pv && pred_taken !== e_pt)) begin
                n_errors++;
                $display("FAIL b2b_pred %0d got v=%b t=%b want %b %b", i, pred_valid, pred_taken, e_pv, e_pt);
            end
        end
        n_checks++;
        if (occupancy !== 3'd4 || br_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full got occ=%0d rdy=%b want 4 0", occupancy, br_ready);
        end
        tick();
        n_checks++;
        if (tbl_get !== 1'b0 || occupancy !== 3'd4) begin
            n_errors++;
            $display("FAIL full_reject got get=%b occ=%0d want 0 4", tbl_get, occupancy);
        end
        res_valid = 1; res_taken = 0; tick();
        n_checks++;
        if (tbl_get !== 1'b0 || tbl_set !== 1'b1 || occupancy !== 3'd3 || br_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL full_pop got get=%b set=%b occ=%0d rdy=%b want 0 1 3 1", tbl_get, tbl_set, occupancy, br_ready);
        end
        br_valid = 0; tick();
        n_checks++;
        if (occupancy !== 3'd2) begin
            n_errors++;
            $display("FAIL pop_to_2 got occ=%0d want 2", occupancy);
        end
        br_valid = 1; br_pc = 8'($urandom); tick();
        n_checks++;
        if (occupancy !== 3'd2 || tbl_get !== 1'b1 || tbl_set !== 1'b1) begin
            n_errors++;
            $display("FAIL acc_and_res got occ=%0d get=%b set=%b want 2 1 1", occupancy, tbl_get, tbl_set);
        end
        idle_inputs(); flush = 1; tick(); flush = 0;
        tick(); tick();
    endtask

    task automatic test_flush();
        logic [7:0] g;
        br_pc = 8'h33; br_valid = 1; tick(); br_valid = 0;
        flush = 1; tick(); flush = 0;
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_errors++;
            $display("FAIL flush_occ got occ=%0d want 0", occupancy);
        end
        tick();
        n_checks++;
        if (pred_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_drop got pred_valid=%b want 0", pred_valid);
        end
        g = m_ghr;
        res_valid = 1; res_taken = 1; tick(); res_valid = 0;
        n_checks++;
        if (tbl_set !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_resolve got set=%b want 0", tbl_set);
        end
        br_pc = 8'h44; br_valid = 1; tick(); br_valid = 0;
        n_checks++;
        if (tbl_get_index !== (8'h44 ^ g)) begin
            n_errors++;
            $display("FAIL ghr_kept got idx=%h want %h", tbl_get_index, 8'h44 ^ g);
        end
        res_valid = 1; res_taken = 1; tick(); res_valid = 0;
        n_checks++;
        if (tbl_set !== 1'b0 || occupancy !== 3'd1) begin
            n_errors++;
            $display("FAIL unfilled_resolve got set=%b occ=%0d want 0 1", tbl_set, occupancy);
        end
        tick(); flush = 1; tick(); flush = 0; tick(); tick();
    endtask

    task automatic test_clear();
        clear = 1; tick(); clear = 0;
        n_checks++;
        if (br_ready !== 1'b0 || tbl_reset !== 1'b1 || tbl_reset_index !== 8'h00) begin
            n_errors++;
            $display("FAIL clear_start got rdy=%b rst=%b idx=%h want 0 1 00", br_ready, tbl_reset, tbl_reset_index);
        end
        for (int i = 1; i < 256; i++) begin
            tick();
            n_checks++;
            if (tbl_reset !== 1'b1 || tbl_reset_index !== 8'(i)) begin
                n_errors++;
                $display("FAIL clear_sweep %0d got rst=%b idx=%h want 1 %h", i, tbl_reset, tbl_reset_index, 8'(i));
            end
        end
        tick();
        br_pc = 8'h5A; br_valid = 1; tick(); br_valid = 0;
        n_checks++;
        if (tbl_get !== 1'b1 || tbl_get_index !== 8'h5A) begin
            n_errors++;
            $display("FAIL clear_ghr got get=%b idx=%h want 1 5a", tbl_get, tbl_get_index);
        end
        flush = 1; tick(); flush = 0; tick(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) tbl_bits[i] = 1'($urandom_range(0, 1));
        for (int c = 0; c < 1500; c++) begin
            br_valid  = 1'($urandom_range(0, 1));
            br_pc     = 8'($urandom);
            res_valid = ($urandom_range(0, 3) != 0);
            res_taken = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 40) == 0);
            clear     = ($urandom_range(0, 600) == 0);
            tick();
            n_checks++;
            if (tbl_get !== e_get || (e_get && tbl_get_index !== e_get_idx)) begin
                n_errors++;
                $display("FAIL rnd_get c=%0d got %b/%h want %b/%h", c, tbl_get, tbl_get_index, e_get, e_get_idx);
            end
            n_checks++;
            if (tbl_set !== e_set || (e_set && (tbl_set_index !== e_set_idx || tbl_feedback !== e_fb))) begin
                n_errors++;
                $display("FAIL rnd_set c=%0d got %b/%h/%b want %b/%h/%b", c, tbl_set, tbl_set_index, tbl_feedback, e_set, e_set_idx, e_fb);
            end
            n_checks++;
            if (mispredict !== e_misp || mispredict_count !== 16'(m_cnt)) begin
                n_errors++;
                $display("FAIL rnd_misp c=%0d got %b/%0d want %b/%0d", c, mispredict, mispredict_count, e_misp, m_cnt);
            end
            n_checks++;
            if (occupancy !== 3'(q.size()) || br_ready !== (m_run && q.size() < 4)) begin
                n_errors++;
                $display("FAIL rnd_occ c=%0d got occ=%0d rdy=%b want %0d %b", c, occupancy, br_ready, q.size(), m_run && q.size() < 4);
            end
            n_checks++;
            if (pred_valid !== e_pv || (e_pv && pred_taken !== e_pt)) begin
                n_errors++;
                $display("FAIL rnd_pred c=%0d got %b/%b want %b/%b", c, pred_valid, pred_taken, e_pv, e_pt);
            end
            n_checks++;
            if (tbl_reset !== (m_pos >= 0) || (m_pos >= 0 && tbl_reset_index !== 8'(m_pos))) begin
                n_errors++;
                $display("FAIL rnd_sweep c=%0d got %b/%h want %b/%0d", c, tbl_reset, tbl_reset_index, m_pos >= 0, m_pos);
            end
        end
        idle_inputs();
        for (int k = 0; k < 300 && !m_run; k++) tick();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        clear = 1; tick(); clear = 0;
        repeat (100) tick();
        n_checks++;
        if (tbl_reset !== 1'b1 || tbl_reset_index !== 8'd100) begin
            n_errors++;
            $display("FAIL pre_reset got rst=%b idx=%0d want 1 100", tbl_reset, tbl_reset_index);
        end
        #2 reset = 1;
        #1;
        n_checks++;
        if (tbl_reset !== 1'b0 || tbl_reset_index !== 8'h00 || br_ready !== 1'b0 ||
            mispredict_count !== 16'd0 || occupancy !== 3'd0) begin
            n_errors++;
            $display("FAIL async_reset got rst=%b idx=%h rdy=%b cnt=%0d occ=%0d want 0 00 0 0 0",
                     tbl_reset, tbl_reset_index, br_ready, mispredict_count, occupancy);
        end
        @(posedge clk);
        @(negedge clk);
        model_reset();
        reset = 0;
        tick();
        n_checks++;
        if (tbl_reset !== 1'b1 || tbl_reset_index !== 8'h00 || br_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL restart got rst=%b idx=%h rdy=%b want 1 00 0", tbl_reset, tbl_reset_index, br_ready);
        end
        repeat (256) tick();
        n_checks++;
        if (tbl_reset !== 1'b0 || br_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_end got rst=%b rdy=%b want 0 1", tbl_reset, br_ready);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sweep();
        test_hash();
        test_mispredict();
        test_full();
        test_flush();
        test_clear();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
